rgb_cycle_pwm: RTL
==================

// Module: rgb_cycle_pwm
// PURPOSE
// - N-channel colour-cycle generator with first-order sigma-delta PWM outputs, driving the RGB LED pins.
// - Sits between the SPI register file (speed/mode/brightness) and the LED pads.
// - Generalises the single-channel cycler: per-channel phase offsets, run-time modes, brightness scaling, clean speed changes.
// PARAMETERS
// - N_CH       3   number of LED channels; phase offset between channels = PERIOD/N_CH
// - PWM_W      8   duty width; PERIOD = 6*2^PWM_W positions (1536 at 8)
// - PRESC_W    20  prescaler width
// - START_POS  0   position loaded at reset, 0..PERIOD-1
// PORTS
// - i_clk     in   1            clock
// - i_rst     in   1            reset
// - i_speed   in   PRESC_W      prescaler terminal count; tick every i_speed+1 clocks
// - i_mode    in   2            0 CYCLE, 1 HOLD, 2 BREATHE, 3 OFF
// - i_bright  in   PWM_W        global brightness scale
// - o_led     out  N_CH         PWM output per channel
// - o_pos     out  POS_W        current position, POS_W = clog2(PERIOD)
// - o_tick    out  1            one-clock pulse on every prescaler tick
// - o_wrap    out  1            one-clock pulse when position wraps PERIOD-1 -> 0
// BEHAVIOUR
// - Reset is i_rst: synchronous, active-high; clock is i_clk. Reset values: prescaler 0, pos START_POS, duties 0, accumulators 0, o_led 0, o_tick 0, o_wrap 0.
// - Prescaler: cnt >= i_speed -> cnt <= 0, tick; else cnt+1. Lowering i_speed below cnt gives a tick next cycle, no 2^PRESC_W stall. i_speed=0 -> tick every clock.
// - o_tick registered: high the cycle after cnt reached terminal.
// - Position advances on tick in CYCLE and BREATHE; frozen in HOLD and OFF. PERIOD-1 -> 0 with o_wrap high for that update cycle.
// - Channel k position q_k = (pos + k*PERIOD/N_CH) mod PERIOD; BREATHE uses q_k = pos for all k.
// - Shape, M = 2^PWM_W: q<M -> q; q<3M -> M-1; q<4M -> 4M-1-q; else 0.
// - Brightness: d = (shape*(i_bright+1)) >> PWM_W; bright=M-1 is identity, bright=0 gives d<=shape>>PWM_W.
// - OFF forces d=0 for all channels.
// - Duty register updated every clock from current pos/mode/bright: 1-cycle latency from pos to duty.
// - Sigma-delta per channel every clock: {c,acc} <= acc + duty; o_led <= c. Duty M-1 -> high (M-1) of every M clocks; duty 0 -> constant low.
// - Mode change takes effect on the next clock: no wait for tick. Accumulators are not cleared on mode change.
// - Reset mid-operation overrides all; first tick after release comes i_speed+1 clocks later.
// CONFIGURATION
// - RGB_CYCLE_GAMMA_EN defined: after brightness, d' = (d*(d+1)) >> PWM_W (0->0, M-1->M-1, M/2 -> M/4 approx); adds one pipeline register, so pos->duty latency becomes 2.
// - Undefined: linear duty, latency 1.
// STRUCTURE
// - Shared include rgb_cycle_defs.vh: mode encodings (RGB_MODE_CYCLE/HOLD/BREATHE/OFF) and the PERIOD/segment localparam formulas.
// - Sub-module sd_pwm (PWM_W): one accumulator plus output register; instantiated N_CH times in a generate loop.
// - Top: prescaler, position counter, shape/brightness/gamma datapath, mode mux.
// TESTING
// - Reset: hold i_rst 3 clks, START_POS=100 -> o_pos=100, o_led=0, o_tick=0 on release.
// - i_speed=0, CYCLE, bright=255: pos 0..1535 -> ch0 duty ramps 0..255 over pos 0..255, 255 up to pos 767, 0 at pos 1024; o_wrap pulses once per 1536 clks.
// - Channel offset: pos=0 -> ch1 q=512 (duty 255), ch2 q=1024 (duty 0).
// - PWM: HOLD with ch0 duty 128 -> exactly 128 high clocks in any aligned 256-clock window; duty 255 -> 255/256.
// - Speed change: i_speed=1000, cnt at 900, set i_speed=10 -> o_tick next-but-one clock, then every 11 clocks.
// - OFF mid-cycle -> all o_led low within 2 clocks, o_pos frozen; back to CYCLE resumes from same pos.

Source files
------------

// File: rtl/rgb_cycle_pwm_pkg.sv
// Shared mode encodings and period/width formulas for the colour-cycle PWM block.
package rgb_cycle_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_CYCLE   = 2'd0,
    MODE_HOLD    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_OFF     = 2'd3
  } mode_t;

  // Six colour-wheel segments, each 2^PWM_W positions long
  localparam int N_SEG = 6;

  function automatic int period_of(input int pwm_w);
    return N_SEG * (1 << pwm_w);
  endfunction

  function automatic int pos_w_of(input int pwm_w);
    return $clog2(period_of(pwm_w));
  endfunction

endpackage

// File: rtl/rgb_cycle_pwm_if.sv
// Control inputs (speed/mode/brightness) and LED/status outputs of the colour-cycle PWM block.
interface rgb_cycle_pwm_if
  import rgb_cycle_pwm_pkg::*;
#(
  parameter int N_CH    = 3,
  parameter int PWM_W   = 8,
  parameter int PRESC_W = 20,
  parameter int POS_W   = pos_w_of(PWM_W)
);
  logic [PRESC_W-1:0] i_speed;
  mode_t              i_mode;
  logic [PWM_W-1:0]   i_bright;
  logic [N_CH-1:0]    o_led;
  logic [POS_W-1:0]   o_pos;
  logic               o_tick;
  logic               o_wrap;

  modport master (output i_speed, i_mode, i_bright, input o_led, o_pos, o_tick, o_wrap);
  modport slave  (input i_speed, i_mode, i_bright, output o_led, o_pos, o_tick, o_wrap);
endinterface

// File: rtl/rgb_cycle_pwm_sd_pwm.sv
// First-order sigma-delta modulator: one accumulator, carry registered onto the pin.
// Latency 1 clock from duty to output; free-running, no backpressure.
module sd_pwm #(
  parameter int PWM_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [PWM_W-1:0] i_duty,
  output logic             o_led
);
  logic [PWM_W-1:0] acc;
  logic [PWM_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, i_duty};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc   <= '0;
      o_led <= 1'b0;
    end else begin
      acc   <= sum[PWM_W-1:0];
      o_led <= sum[PWM_W];
    end
  end
endmodule

// File: rtl/rgb_cycle_pwm.sv
// N-channel colour cycler: prescaler, position counter, shape/brightness duty, sigma-delta pins.
// Pos->duty latency 1 clock (2 with RGB_CYCLE_GAMMA_EN); free-running outputs, no backpressure.
module rgb_cycle_pwm
  import rgb_cycle_pwm_pkg::*;
#(
  parameter int N_CH      = 3,
  parameter int PWM_W     = 8,
  parameter int PRESC_W   = 20,
  parameter int START_POS = 0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  rgb_cycle_pwm_if.slave bus
);
  localparam int PERIOD = period_of(PWM_W);
  localparam int POS_W  = pos_w_of(PWM_W);
  localparam int M      = 1 << PWM_W;
  localparam int PW     = 2 * PWM_W + 1;

  localparam logic [POS_W-1:0] RISE_END = POS_W'(M);
  localparam logic [POS_W-1:0] HIGH_END = POS_W'(3 * M);
  localparam logic [POS_W-1:0] FALL_END = POS_W'(4 * M);
  localparam logic [POS_W-1:0] FALL_TOP = POS_W'(4 * M - 1);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(PERIOD - 1);
  localparam logic [POS_W:0]   PERIOD_X = (POS_W+1)'(PERIOD);

  mode_t              mode;
  logic [PRESC_W-1:0] cnt;
  logic               term;
  logic               advance;
  logic               tick_q;
  logic               wrap_q;
  logic [POS_W-1:0]   pos;
  logic [N_CH-1:0]    led;

  assign mode    = bus.i_mode;
  assign term    = (cnt >= bus.i_speed);
  assign advance = term && ((mode == MODE_CYCLE) || (mode == MODE_BREATHE));

  // ">=" rather than "==" so lowering the speed below cnt ticks at once
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt    <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= term;
      cnt    <= term ? '0 : cnt + PRESC_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pos    <= POS_W'(START_POS);
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (advance) begin
        if (pos == LAST_POS) begin
          pos    <= '0;
          wrap_q <= 1'b1;
        end else begin
          pos <= pos + POS_W'(1);
        end
      end
    end
  end

  function automatic logic [PWM_W-1:0] shape(input logic [POS_W-1:0] q);
    if (q < RISE_END)      return q[PWM_W-1:0];
    else if (q < HIGH_END) return PWM_W'(M - 1);
    else if (q < FALL_END) return PWM_W'(FALL_TOP - q);
    else                   return '0;
  endfunction

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    localparam logic [POS_W:0] OFFS = (POS_W+1)'((k * PERIOD) / N_CH);

    logic [POS_W:0]   sum;
    logic [POS_W-1:0] q;
    logic [PWM_W-1:0] sh;
    logic [PW-1:0]    prod;
    logic [PWM_W-1:0] d;
    logic [PWM_W-1:0] duty_q;
    logic [PWM_W-1:0] duty_use;

    always_comb begin
      sum = (mode == MODE_BREATHE) ? {1'b0, pos} : ({1'b0, pos} + OFFS);
      if (sum >= PERIOD_X) sum = sum - PERIOD_X;
      q    = sum[POS_W-1:0];
      sh   = shape(q);
      prod = PW'(sh) * PW'({1'b0, bus.i_bright} + (PWM_W+1)'(1));
      d    = (mode == MODE_OFF) ? '0 : PWM_W'(prod >> PWM_W);
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) duty_q <= '0;
      else       duty_q <= d;
    end

`ifdef RGB_CYCLE_GAMMA_EN
    // OFF also clears the gamma stage so the pins still go dark within two clocks
    logic [PWM_W-1:0] gam_q;
    always_ff @(posedge i_clk) begin
      if (i_rst)                 gam_q <= '0;
      else if (mode == MODE_OFF) gam_q <= '0;
      else gam_q <= PWM_W'((PW'(duty_q) * PW'({1'b0, duty_q} + (PWM_W+1)'(1))) >> PWM_W);
    end
    assign duty_use = gam_q;
`else
    assign duty_use = duty_q;
`endif

    sd_pwm #(.PWM_W(PWM_W)) u_pwm (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_duty (duty_use),
      .o_led  (led[k])
    );
  end

  assign bus.o_led  = led;
  assign bus.o_pos  = pos;
  assign bus.o_tick = tick_q;
  assign bus.o_wrap = wrap_q;
endmodule
